// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for a 5-stage pipeline with a multi-cycle execute unit.
// Provides operand forwarding, load-use stall detection, and a stall FSM
// that holds a mul/div op in Execute for MC_LAT cycles. It also keeps
// saturating stall and flush performance counters.
module hazard_ctrl_mc #(
  parameter int REG_W  = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic [1:0]       PCSrcE,
  input  logic             McOpE,
  input  logic             ClrCnt,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             McDone,
  output logic             McBusy,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  // Down-counter width: enough to hold MC_LAT-2, never narrower than one bit.
  localparam int CW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((MC_LAT > 1) ? (MC_LAT - 2) : 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            mc_stall, mc_done, lw_stall, redirect;

  // Forwarding select: Memory-stage result wins over Writeback; x0 is never forwarded.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Multi-cycle FSM next state: the first MC_LAT-1 cycles stall, the last one signals done.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mc_stall   = 1'b0;
    mc_done    = 1'b0;
    case (state)
      IDLE: begin
        if (McOpE) begin
          if (MC_LAT > 1) begin
            mc_stall   = 1'b1;
            cnt_next   = CNT_LOAD;
            state_next = BUSY;
          end else begin
            mc_done = 1'b1;
          end
        end
      end
      BUSY: begin
        if (!McOpE) begin
          state_next = IDLE;
        end else if (cnt != '0) begin
          mc_stall = 1'b1;
          cnt_next = cnt - CW'(1);
        end else begin
          mc_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Stall/flush outputs, all forced low while reset is held.
  always_comb begin
    redirect = (PCSrcE != 2'b00) && !mc_stall;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    McDone   = 1'b0;
    if (!rst) begin
      StallF = lw_stall | mc_stall;
      StallD = lw_stall | mc_stall;
      StallE = mc_stall;
      FlushM = mc_stall;
      FlushD = redirect;
      FlushE = (lw_stall | redirect) & !mc_stall;
      McDone = mc_done;
    end
  end

  assign McBusy = (state == BUSY);

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || ClrCnt) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushD && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule
